// File: rtl/layer_sequencer.sv
// Layer sequencer: steps a CNN datapath through a descriptor table, one layer per
// start_layer pulse, with per-layer watchdog, abort and error reporting.
module layer_sequencer #(
    parameter  int MAX_LAYER = 16,
    parameter  int ADDR_W    = 22,
    parameter  int TMO_W     = 24,
    localparam int LW        = $clog2(MAX_LAYER + 1),
    localparam int DESC_W    = 37 + 2 * ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [LW-1:0]     cfg_addr,
    input  logic [DESC_W-1:0] cfg_wdata,
    input  logic [LW-1:0]     num_layer,
    input  logic [TMO_W-1:0]  timeout_limit,
    input  logic              start_cnn,
    input  logic              abort,
    input  logic              done_layer,
    output logic              start_layer,
    output logic              done_cnn,
    output logic              aborted,
    output logic              busy,
    output logic              error,
    output logic [LW-1:0]     count_layer,
    output logic [8:0]        ifm_size,
    output logic [10:0]       ifm_channel,
    output logic [1:0]        kernel_size,
    output logic [10:0]       num_filter,
    output logic              maxpool_mode,
    output logic [1:0]        maxpool_stride,
    output logic              upsample_mode,
    output logic [ADDR_W-1:0] start_write_addr,
    output logic [ADDR_W-1:0] start_read_addr
);

    localparam int AW = (MAX_LAYER > 1) ? $clog2(MAX_LAYER) : 1;

    typedef struct packed {
        logic [8:0]        ifm_size;
        logic [10:0]       ifm_channel;
        logic [1:0]        kernel_size;
        logic [10:0]       num_filter;
        logic              maxpool_mode;
        logic [1:0]        maxpool_stride;
        logic              upsample_mode;
        logic [ADDR_W-1:0] start_write_addr;
        logic [ADDR_W-1:0] start_read_addr;
    } desc_t;

    typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, RUN, DONE} state_t;

    state_t           state, state_d;
    desc_t            desc_mem [MAX_LAYER];
    desc_t            cfg_q;
    logic [LW-1:0]    num_q;
    logic [TMO_W-1:0] wdog;
    logic [AW-1:0]    rd_idx, wr_idx;
    logic             start_ok, wdog_exp;
    logic             accept, reject, advance, expire, abort_hit, load_cfg;

    assign rd_idx   = AW'(count_layer - LW'(1));
    assign wr_idx   = AW'(cfg_addr);
    assign start_ok = (num_layer != '0) && (num_layer <= LW'(MAX_LAYER));
    assign wdog_exp = (timeout_limit != '0) && (wdog == timeout_limit - TMO_W'(1));

    // Table has no reset so descriptors survive a reset between runs.
    always_ff @(posedge clk) begin
        if (cfg_we && state == IDLE && cfg_addr < LW'(MAX_LAYER))
            desc_mem[wr_idx] <= desc_t'(cfg_wdata);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        reject    = 1'b0;
        advance   = 1'b0;
        expire    = 1'b0;
        abort_hit = 1'b0;
        case (state)
            IDLE: begin
                if (start_cnn) begin
                    if (start_ok) begin
                        accept  = 1'b1;
                        state_d = LOAD;
                    end else begin
                        reject  = 1'b1;
                    end
                end
            end
            LOAD:   state_d = LAUNCH;
            LAUNCH: state_d = RUN;
            RUN: begin
                // done_layer outranks a coincident watchdog expiry
                if (done_layer) begin
                    if (count_layer < num_q) begin
                        advance = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end else if (wdog_exp) begin
                    expire  = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state != IDLE) begin
            abort_hit = 1'b1;
            advance   = 1'b0;
            expire    = 1'b0;
            state_d   = IDLE;
        end
    end

    assign load_cfg    = (state == LOAD) && !abort_hit;
    assign start_layer = (state == LAUNCH) && !abort;
    assign done_cnn    = (state == DONE) && !abort;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_layer <= '0;
            num_q       <= '0;
            error       <= 1'b0;
            aborted     <= 1'b0;
            cfg_q       <= '0;
            wdog        <= '0;
        end else begin
            aborted <= abort_hit;
            if (accept) begin
                count_layer <= LW'(1);
                num_q       <= num_layer;
                error       <= 1'b0;
            end else if (advance) begin
                count_layer <= count_layer + LW'(1);
            end
            if (reject || expire)
                error <= 1'b1;
            if (load_cfg)
                cfg_q <= desc_mem[rd_idx];
            // Counts RUN cycles from the launch; saturates if left disabled.
            if (state == LAUNCH)
                wdog <= '0;
            else if (state == RUN && wdog != '1)
                wdog <= wdog + TMO_W'(1);
        end
    end

    assign ifm_size         = cfg_q.ifm_size;
    assign ifm_channel      = cfg_q.ifm_channel;
    assign kernel_size      = cfg_q.kernel_size;
    assign num_filter       = cfg_q.num_filter;
    assign maxpool_mode     = cfg_q.maxpool_mode;
    assign maxpool_stride   = cfg_q.maxpool_stride;
    assign upsample_mode    = cfg_q.upsample_mode;
    assign start_write_addr = cfg_q.start_write_addr;
    assign start_read_addr  = cfg_q.start_read_addr;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: multi-layer run, bad starts, watchdog,
// abort, write protection while busy and reset mid-run.
module tb_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst, cfg_we, start_cnn, abort, done_layer;
    logic [4:0]  cfg_addr, num_layer;
    logic [80:0] cfg_wdata;
    logic [23:0] timeout_limit;
    logic        start_layer, done_cnn, aborted, busy, error;
    logic [4:0]  count_layer;
    logic [8:0]  ifm_size;
    logic [10:0] ifm_channel, num_filter;
    logic [1:0]  kernel_size, maxpool_stride;
    logic        maxpool_mode, upsample_mode;
    logic [21:0] start_write_addr, start_read_addr;

    logic [80:0] dw [3];
    logic [80:0] junk;
    wire  [80:0] cfg_obs = {ifm_size, ifm_channel, kernel_size, num_filter, maxpool_mode,
                            maxpool_stride, upsample_mode, start_write_addr, start_read_addr};
    int vectors = 0;
    int miscompares = 0;

    layer_sequencer dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .num_layer(num_layer), .timeout_limit(timeout_limit), .start_cnn(start_cnn),
        .abort(abort), .done_layer(done_layer), .start_layer(start_layer),
        .done_cnn(done_cnn), .aborted(aborted), .busy(busy), .error(error),
        .count_layer(count_layer), .ifm_size(ifm_size), .ifm_channel(ifm_channel),
        .kernel_size(kernel_size), .num_filter(num_filter), .maxpool_mode(maxpool_mode),
        .maxpool_stride(maxpool_stride), .upsample_mode(upsample_mode),
        .start_write_addr(start_write_addr), .start_read_addr(start_read_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [80:0] d);
        cfg_addr  = a;
        cfg_wdata = d;
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic start(input logic [4:0] n);
        num_layer = n;
        start_cnn = 1'b1;
        tick();
        start_cnn = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; start_cnn = 1'b0; abort = 1'b0; done_layer = 1'b0;
        cfg_addr = '0; cfg_wdata = '0; num_layer = '0; timeout_limit = '0;
        dw[0] = {9'd416, 11'd3,  2'd1, 11'd16,  1'b1, 2'd2, 1'b0, 22'h001000, 22'h000000};
        dw[1] = {9'd208, 11'd16, 2'd3, 11'd32,  1'b0, 2'd1, 1'b1, 22'h020000, 22'h001000};
        dw[2] = {9'd104, 11'd32, 2'd2, 11'd255, 1'b1, 2'd1, 1'b0, 22'h3FFFFF, 22'h020000};
        junk  = {81{1'b1}};
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_count", count_layer, 0);
        check("rst_cfg", cfg_obs, 0);
        check("rst_pulses", {start_layer, done_cnn, aborted}, 0);
        rst = 1'b0;
        tick();

        wr(5'd0, dw[0]); wr(5'd1, dw[1]); wr(5'd2, dw[2]);
        wr(5'd16, junk);

        // three-layer run, watchdog disabled
        start(5'd3);
        check("r1_t1_start_layer", start_layer, 0);
        check("r1_t1_busy", busy, 1);
        tick();
        check("r1_t2_start_layer", start_layer, 1);
        check("r1_t2_count", count_layer, 1);
        check("r1_t2_cfg", cfg_obs, dw[0]);
        tick();
        check("r1_run_start_layer", start_layer, 0);
        cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = junk; start_cnn = 1'b1; num_layer = 5'd1;
        tick();
        cfg_we = 1'b0; start_cnn = 1'b0;
        check("r1_busy_start_ignored", {start_layer, count_layer}, {1'b0, 5'd1});
        check("r1_cfg_stable", cfg_obs, dw[0]);
        done_layer = 1'b1; tick(); done_layer = 1'b0;
        check("r1_d1_start_layer", start_layer, 0);
        tick();
        check("r1_l2_start_layer", start_layer, 1);
        check("r1_l2_count", count_layer, 2);
        check("r1_l2_cfg", cfg_obs, dw[1]);
        tick();
        done_layer = 1'b1; tick(); done_layer = 1'b0;
        tick();
        check("r1_l3_start_layer", start_layer, 1);
        check("r1_l3_count", count_layer, 3);
        check("r1_l3_cfg", cfg_obs, dw[2]);
        tick(); tick();
        done_layer = 1'b1; tick(); done_layer = 1'b0;
        check("r1_done_cnn", {done_cnn, busy, start_layer}, 3'b110);
        tick();
        check("r1_idle", {done_cnn, busy}, 2'b00);
        check("r1_hold_count", count_layer, 3);
        check("r1_hold_cfg", cfg_obs, dw[2]);
        done_layer = 1'b1; tick(); done_layer = 1'b0;
        check("idle_done_ignored", {busy, done_cnn, start_layer}, 0);

        // out-of-range layer count, then a valid start clears the error
        start(5'd17);
        check("n17_error", {error, busy}, 2'b10);
        tick();
        check("n17_no_launch", start_layer, 0);
        start(5'd1);
        check("n1_error_clear", {error, busy}, 2'b01);
        tick();
        check("n1_start_layer", start_layer, 1);
        check("n1_cfg_table_protected", cfg_obs, dw[0]);
        tick();
        done_layer = 1'b1; tick(); done_layer = 1'b0;
        check("n1_done_cnn", done_cnn, 1);
        tick();
        start(5'd0);
        check("n0_error", {error, busy}, 2'b10);
        tick();
        check("n0_no_launch", {start_layer, busy}, 0);

        // watchdog expiry with done_layer withheld
        timeout_limit = 24'd10;
        start(5'd1);
        tick();
        check("wd_start_layer", start_layer, 1);
        repeat (10) tick();
        check("wd_l10_busy", {busy, error, done_cnn}, 3'b100);
        tick();
        check("wd_l11_expired", {busy, error, done_cnn}, 3'b010);
        tick();
        check("wd_no_done_cnn", {done_cnn, busy}, 0);

        // done_layer coinciding with expiry wins
        timeout_limit = 24'd3;
        start(5'd1);
        tick();
        tick(); tick(); tick();
        done_layer = 1'b1; tick(); done_layer = 1'b0;
        check("wd_tie_done_cnn", {done_cnn, error}, 2'b10);
        tick();
        check("wd_tie_idle", busy, 0);

        // watchdog disabled: waits, then abort
        timeout_limit = 24'd0;
        start(5'd1);
        tick();
        repeat (40) tick();
        check("wd_off_waiting", {busy, error}, 2'b10);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_run", {aborted, busy, done_cnn}, 3'b100);
        tick();
        check("abort_pulse_once", aborted, 0);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_idle_noeffect", {aborted, busy}, 0);

        // abort coincident with done_layer during layer 2
        start(5'd3);
        tick();
        tick();
        done_layer = 1'b1; tick(); done_layer = 1'b0;
        tick();
        check("ab2_l2_launch", {start_layer, count_layer}, {1'b1, 5'd2});
        tick(); tick();
        abort = 1'b1; done_layer = 1'b1; tick(); abort = 1'b0; done_layer = 1'b0;
        check("ab2_aborted", {aborted, busy, start_layer}, 3'b100);
        tick();
        check("ab2_once", {aborted, start_layer}, 0);
        tick();
        check("ab2_no_l3", {start_layer, busy, count_layer}, {2'b00, 5'd2});

        // reset mid-run, then rerun without reloading the table
        start(5'd3);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("rstmid_outputs", {start_layer, done_cnn, aborted, busy, error, count_layer}, 0);
        check("rstmid_cfg", cfg_obs, 0);
        tick();
        rst = 1'b0;
        tick();
        check("rstmid_after", {busy, aborted, done_cnn}, 0);
        start(5'd3);
        tick();
        check("rerun_l1", {start_layer, count_layer}, {1'b1, 5'd1});
        check("rerun_l1_cfg", cfg_obs, dw[0]);
        tick();
        done_layer = 1'b1; tick(); done_layer = 1'b0;
        tick();
        check("rerun_l2_cfg", cfg_obs, dw[1]);
        abort = 1'b1; tick(); abort = 1'b0;
        check("rerun_abort_in_launch", {aborted, busy}, 2'b10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
